axis_frame_generator: RTL and testbench

//  AXI-Stream transmitter: builds framed test traffic (deterministic data ramp, tlast, tkeep)
//  and drives it into stream slaves such as axis_pipeline_adder. Software-style cfg_* inputs

---
 rtl/axis_frame_generator_if.sv | 15 +
 rtl/axis_frame_generator.sv | 205 ++++++++++++++++++++
 tb/tb_axis_frame_generator.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_generator_if.sv
// rtl/axis_frame_generator_if.sv - AXI-Stream style link between the frame generator and a stream slave
interface axis_frame_generator_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [BYTES-1:0]      tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/axis_frame_generator.sv
// rtl/axis_frame_generator.sv - burst generator of framed ramp traffic with registered AXIS outputs
module axis_frame_generator #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_WIDTH-1:0]  cfg_byte_len,
  input  logic [15:0]           cfg_num_frames,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  axis_frame_generator_if.master m_axis,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [15:0]           sts_frame_cnt
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t state_q, state_d;

  logic [LEN_WIDTH-1:0]  beats_q, beats_d;          // beats per frame of the running burst
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d; // beats not yet presented in this frame
  logic [BYTES-1:0]      keep_last_q, keep_last_d;
  logic [15:0]           frames_left_q, frames_left_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] next_data_q, next_data_d;   // value the next presented beat carries
  logic                  stop_pend_q, stop_pend_d;
  logic                  done_q, done_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [BYTES-1:0]      tkeep_q, tkeep_d;

  logic                  hs, last_hs, stop_now, start_ok, load;
  logic [LEN_WIDTH:0]    len_round;
  logic [LEN_WIDTH-1:0]  start_beats, len_mod, cur_beats;
  logic [BYTES-1:0]      start_keep;

  assign hs       = tvalid_q & m_axis.tready;
  assign last_hs  = hs & tlast_q;
  assign stop_now = stop_pend_q | cfg_stop;
  // A start landing on the done cycle is dropped so the new burst waits for a clean IDLE cycle.
  assign start_ok = cfg_start & ~done_q & (cfg_byte_len != '0) & (cfg_num_frames != '0);

  // Frame geometry derived from the requested byte length, latched at start.
  always_comb begin
    len_round   = {1'b0, cfg_byte_len} + (LEN_WIDTH + 1)'(BYTES - 1);
    start_beats = LEN_WIDTH'(len_round >> BSHIFT);
    len_mod     = cfg_byte_len % LEN_WIDTH'(BYTES);
    start_keep  = '0;
    for (int i = 0; i < BYTES; i++) begin
      start_keep[i] = (len_mod == '0) || (LEN_WIDTH'(i) < len_mod);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decision: frames are only ever left on their tlast handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_SEND;
      S_SEND: begin
        if (last_hs) begin
          if ((frames_left_q == 16'd1) || stop_now) state_d = S_IDLE;
          else if (gap_q != '0)                     state_d = S_GAP;
          else                                      state_d = S_SEND;
        end
      end
      S_GAP: begin
        if (stop_now)                 state_d = S_IDLE;
        else if (gap_cnt_q == 'd1)    state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; a beat is loaded whenever the output slot is empty or drains.
  always_comb begin
    beats_d       = beats_q;
    beats_left_d  = beats_left_q;
    keep_last_d   = keep_last_q;
    frames_left_d = frames_left_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    step_d        = step_q;
    next_data_d   = next_data_q;
    frame_cnt_d   = frame_cnt_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tkeep_d       = tkeep_q;
    load          = 1'b0;
    cur_beats     = beats_left_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          beats_d       = start_beats;
          beats_left_d  = start_beats;
          keep_last_d   = start_keep;
          frames_left_d = cfg_num_frames;
          gap_d         = cfg_gap;
          step_d        = cfg_step;
          next_data_d   = cfg_seed;
          frame_cnt_d   = '0;
          tvalid_d      = 1'b0;
        end
      end
      S_SEND: begin
        if (last_hs) begin
          frame_cnt_d   = frame_cnt_q + 16'd1;
          frames_left_d = frames_left_q - 16'd1;
          tvalid_d      = 1'b0;
          tlast_d       = 1'b0;
          if (state_d == S_SEND) begin
            load      = 1'b1;
            cur_beats = beats_q;
          end else if (state_d == S_GAP) begin
            gap_cnt_d = gap_q;
          end
        end else if ((!tvalid_q || hs) && (beats_left_q != '0)) begin
          load = 1'b1;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (state_d == S_SEND) begin
          load      = 1'b1;
          cur_beats = beats_q;
        end
      end
      default: ;
    endcase
    if (load) begin
      tvalid_d     = 1'b1;
      tdata_d      = next_data_q;
      next_data_d  = next_data_q + step_q;
      tlast_d      = (cur_beats == 'd1);
      tkeep_d      = (cur_beats == 'd1) ? keep_last_q : '1;
      beats_left_d = cur_beats - 1'b1;
    end
    stop_pend_d = stop_pend_q;
    if (state_d == S_IDLE)                   stop_pend_d = 1'b0;
    else if (cfg_stop && state_q != S_IDLE)  stop_pend_d = 1'b1;
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_q       <= '0;
      beats_left_q  <= '0;
      keep_last_q   <= '0;
      frames_left_q <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      step_q        <= '0;
      next_data_q   <= '0;
      stop_pend_q   <= 1'b0;
      done_q        <= 1'b0;
      frame_cnt_q   <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tkeep_q       <= '0;
    end else begin
      beats_q       <= beats_d;
      beats_left_q  <= beats_left_d;
      keep_last_q   <= keep_last_d;
      frames_left_q <= frames_left_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      step_q        <= step_d;
      next_data_q   <= next_data_d;
      stop_pend_q   <= stop_pend_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tkeep_q       <= tkeep_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tkeep  = tkeep_q;
  assign sts_busy      = (state_q != S_IDLE);
  assign sts_done      = done_q;
  assign sts_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_axis_frame_generator.sv
// tb/tb_axis_frame_generator.sv - scoreboard bench for axis_frame_generator
module tb_axis_frame_generator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [15:0] cfg_byte_len = '0;
  logic [15:0] cfg_num_frames = '0;
  logic [7:0]  cfg_gap = '0;
  logic [31:0] cfg_seed = '0;
  logic [31:0] cfg_step = '0;
  logic        sts_busy, sts_done;
  logic [15:0] sts_frame_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;

  beat_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  axis_frame_generator_if #(.DATA_WIDTH(32)) axis_if ();

  axis_frame_generator #(.DATA_WIDTH(32), .LEN_WIDTH(16), .GAP_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_byte_len(cfg_byte_len), .cfg_num_frames(cfg_num_frames), .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed), .cfg_step(cfg_step),
    .m_axis(axis_if),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_frame_cnt(sts_frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_burst(input int len, input int frames, input logic [31:0] seed, input logic [31:0] step);
    int nb = (len + 3) / 4;
    int r = len % 4;
    logic [31:0] d = seed;
    beat_t b;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < nb; i++) begin
        b.data = d;
        b.last = (i == nb - 1);
        b.keep = b.last ? ((r == 0) ? 4'hF : (4'hF >> (4 - r))) : 4'hF;
        exp_q.push_back(b);
        d = d + step;
      end
    end
  endtask

  task automatic pulse_start(input int len, input int frames, input int gap, input logic [31:0] seed, input logic [31:0] step);
    @(negedge clk);
    cfg_byte_len   = 16'(len);
    cfg_num_frames = 16'(frames);
    cfg_gap        = 8'(gap);
    cfg_seed       = seed;
    cfg_step       = step;
    cfg_start      = 1'b1;
    @(negedge clk);
    cfg_start      = 1'b0;
  endtask

  // Runs the stream until done, popping the scoreboard on every handshake.
  task automatic drain(input int mode, input int act_beat, input int act_kind, input int exp_gap,
                       input int max_cyc, output int first_valid, output int beats, output int dones);
    beat_t prev, exp, got;
    logic stalled = 1'b0;
    logic after_last = 1'b0;
    int idle_run = 0;
    first_valid = -1;
    beats = 0;
    dones = 0;
    prev = '0;
    for (int cyc = 0; cyc < max_cyc && dones == 0; cyc++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      got = {axis_if.tdata, axis_if.tlast, axis_if.tkeep};
      if (stalled) begin
        tests_run++;
        if (axis_if.tvalid !== 1'b1 || got !== prev) begin
          tests_failed++;
          $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h", axis_if.tvalid, got, prev);
        end
      end
      axis_if.tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sts_done === 1'b1) dones++;
      if (axis_if.tvalid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (after_last && exp_gap >= 0) begin
          tests_run++;
          if (idle_run !== exp_gap) begin
            tests_failed++;
            $display("FAIL gap: got %0d idle cycles, required %0d", idle_run, exp_gap);
          end
        end
        after_last = 1'b0;
        idle_run = 0;
        if (axis_if.tready) begin
          beats++;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL extra_beat: got beat=%h, required no beat", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              tests_failed++;
              $display("FAIL beat%0d: got data=%h last=%b keep=%b, required data=%h last=%b keep=%b",
                       beats, got.data, got.last, got.keep, exp.data, exp.last, exp.keep);
            end
          end
          if (got.last) after_last = 1'b1;
          if (beats == act_beat && act_kind == 1) cfg_stop = 1'b1;
          if (beats == act_beat && act_kind == 2) begin
            cfg_start = 1'b1;
            cfg_seed = 32'hDEAD_0000;
            cfg_byte_len = 16'd3;
            cfg_num_frames = 16'd9;
            cfg_gap = 8'd4;
          end
        end
      end else if (after_last) begin
        idle_run++;
      end
      stalled = axis_if.tvalid && !axis_if.tready;
      prev = got;
    end
    tests_run++;
    if (dones == 0) begin
      tests_failed++;
      $display("FAIL timeout: got no done within %0d cycles, required done pulse", max_cyc);
    end
    axis_if.tready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0 || axis_if.tkeep !== 4'h0 ||
        axis_if.tdata !== 32'h0 || sts_busy !== 1'b0 || sts_done !== 1'b0 || sts_frame_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b last=%b keep=%h data=%h busy=%b done=%b cnt=%0d, required all 0",
               axis_if.tvalid, axis_if.tlast, axis_if.tkeep, axis_if.tdata, sts_busy, sts_done, sts_frame_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    int fv, nb, nd;
    push_burst(10, 1, 32'h100, 32'h1);
    pulse_start(10, 1, 0, 32'h100, 32'h1);
    tests_run++;
    if (axis_if.tvalid !== 1'b0 || sts_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_latency_early: got valid=%b busy=%b, required valid=0 busy=1", axis_if.tvalid, sts_busy);
    end
    drain(0, 0, 0, -1, 50, fv, nb, nd);
    tests_run++;
    if (fv !== 0) begin
      tests_failed++;
      $display("FAIL start_latency: got first valid at %0d, required 0", fv);
    end
    tests_run++;
    if (nb !== 3 || sts_frame_cnt !== 16'd1 || sts_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_summary: got beats=%0d cnt=%0d busy=%b, required 3 1 0", nb, sts_frame_cnt, sts_busy);
    end
    @(negedge clk);
    tests_run++;
    if (sts_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_width: got done=%b one cycle later, required 0", sts_done);
    end
  endtask

  task automatic test_gap();
    int fv, nb, nd;
    push_burst(8, 3, 32'h0, 32'h1);
    pulse_start(8, 3, 2, 32'h0, 32'h1);
    drain(0, 0, 0, 2, 100, fv, nb, nd);
    tests_run++;
    if (nb !== 6 || sts_frame_cnt !== 16'd3 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL gap_summary: got beats=%0d cnt=%0d left=%0d, required 6 3 0", nb, sts_frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int fv, nb, nd;
    push_burst(5, 3, 32'h40, 32'h10);
    pulse_start(5, 3, 0, 32'h40, 32'h10);
    drain(0, 0, 0, 0, 100, fv, nb, nd);
    tests_run++;
    if (nb !== 6 || sts_frame_cnt !== 16'd3 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_summary: got beats=%0d cnt=%0d left=%0d, required 6 3 0", nb, sts_frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int fv, nb, nd;
    push_burst(40, 2, 32'hFFFF_FFFE, 32'h1);
    pulse_start(40, 2, 1, 32'hFFFF_FFFE, 32'h1);
    drain(1, 0, 0, -1, 400, fv, nb, nd);
    tests_run++;
    if (nb !== 20 || sts_frame_cnt !== 16'd2 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL bp_summary: got beats=%0d cnt=%0d left=%0d, required 20 2 0", nb, sts_frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_stop();
    int fv, nb, nd;
    int extra = 0;
    push_burst(16, 1, 32'h2000, 32'h4);
    pulse_start(16, 5, 3, 32'h2000, 32'h4);
    drain(0, 2, 1, -1, 100, fv, nb, nd);
    tests_run++;
    if (nb !== 4 || sts_frame_cnt !== 16'd1 || sts_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_summary: got beats=%0d cnt=%0d busy=%b, required 4 1 0", nb, sts_frame_cnt, sts_busy);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axis_if.tvalid === 1'b1) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL stop_quiet: got %0d valid cycles after stop, required 0", extra);
    end
  endtask

  task automatic test_bad_start();
    int fv, nb, nd;
    int bad = 0;
    pulse_start(0, 3, 0, 32'h1, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (axis_if.tvalid !== 1'b0 || sts_busy !== 1'b0 || sts_done !== 1'b0) bad++;
    end
    pulse_start(4, 0, 0, 32'h1, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (axis_if.tvalid !== 1'b0 || sts_busy !== 1'b0 || sts_done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL zero_cfg_start: got %0d active cycles, required 0", bad);
    end
    push_burst(12, 2, 32'h50, 32'h3);
    pulse_start(12, 2, 0, 32'h50, 32'h3);
    drain(0, 2, 2, 0, 100, fv, nb, nd);
    tests_run++;
    if (nb !== 6 || sts_frame_cnt !== 16'd2 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL busy_start_summary: got beats=%0d cnt=%0d left=%0d, required 6 2 0", nb, sts_frame_cnt, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (axis_if.tvalid === 1'b1 || sts_busy === 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL busy_start_quiet: got %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int fv, nb, nd;
    pulse_start(4, 5, 0, 32'h0, 32'h1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (axis_if.tvalid !== 1'b0 || sts_busy !== 1'b0 || sts_frame_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got valid=%b busy=%b cnt=%0d, required 0 0 0", axis_if.tvalid, sts_busy, sts_frame_cnt);
    end
    rst_n = 1'b1;
    exp_q.delete();
    push_burst(6, 1, 32'h77, 32'h2);
    pulse_start(6, 1, 0, 32'h77, 32'h2);
    drain(0, 0, 0, -1, 50, fv, nb, nd);
    tests_run++;
    if (nb !== 2 || sts_frame_cnt !== 16'd1 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_burst: got beats=%0d cnt=%0d left=%0d, required 2 1 0", nb, sts_frame_cnt, exp_q.size());
    end
  endtask

  initial begin
    axis_if.tready = 1'b1;
    test_reset();
    test_single_frame();
    test_gap();
    test_back_to_back();
    test_backpressure();
    test_stop();
    test_bad_start();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
